alu_muldiv: RTL and testbench

Iterative multiply/divide unit that extends the combinational ALU with MIPS-style MULT/MULTU/DIV/DIVU. It is parametrised in operand width and holds the HI/LO result registers. It sits beside the ALU in the execute stage. The controller launches it with a start pulse and polls busy/done, and reads HI/LO for mfhi/mflo. Results come from a radix-2 shift-add multiplier and a restoring divider running on magnitudes, with a final sign-fix cycle.

---
 rtl/alu_muldiv_if.sv | 28 ++
 rtl/alu_muldiv.sv | 141 ++++++++++++++
 tb/tb_alu_muldiv.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Controller-side bus of the iterative multiply/divide unit: launch handshake,
// operands, mthi/mtlo write port and the HI/LO/status read-back.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, inA, inB, hi_we, lo_we, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, inA, inB, hi_we, lo_we, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative MIPS-style MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Works on operand magnitudes: radix-2 shift-add multiply or restoring divide
// for WIDTH cycles, then one cycle that applies the result signs and writes HI/LO.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic               is_div_reg;
  logic               neg_main_reg;   // product / quotient must be negated
  logic               neg_rem_reg;    // remainder takes the dividend sign
  logic               dbz_pend_reg;   // current divide has a zero divisor
  logic [WIDTH-1:0]   addend_reg;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               dbz_reg, done_reg;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_upper, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, lo_fix, hi_fix;
  logic               last_iter;

  // Operand conditioning at launch: magnitudes for signed ops, raw for unsigned.
  always_comb begin
    is_signed = ~bus.op[0];
    a_neg     = is_signed & bus.inA[WIDTH-1];
    b_neg     = is_signed & bus.inB[WIDTH-1];
    a_mag     = a_neg ? -bus.inA : bus.inA;
    b_mag     = b_neg ? -bus.inB : bus.inB;
  end

  // One iteration: shift-add on the multiplier LSB, or restoring trial subtract.
  // A zero divisor never borrows, so it naturally yields quotient all-ones and
  // remainder equal to the dividend.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend_reg & {WIDTH{acc_reg[0]}}};
    div_upper = acc_reg[2*WIDTH-1:WIDTH-1];
    div_trial = div_upper - {1'b0, addend_reg};
    if (!is_div_reg) begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end else if (!div_trial[WIDTH]) begin
      acc_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {acc_reg[2*WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up applied in the final cycle, all modulo 2^WIDTH.
  always_comb begin
    prod_fix = neg_main_reg ? -acc_reg : acc_reg;
    quo      = acc_reg[WIDTH-1:0];
    rem      = acc_reg[2*WIDTH-1:WIDTH];
    lo_fix   = dbz_pend_reg ? {WIDTH{1'b1}} : (neg_main_reg ? -quo : quo);
    hi_fix   = neg_rem_reg ? -rem : rem;
  end

  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: IDLE -> CALC on start, CALC for WIDTH iterations, FIX for one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch on launch, iteration, result write, mthi/mtlo writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_main_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      dbz_pend_reg <= 1'b0;
      addend_reg   <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      dbz_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cnt_reg      <= '0;
            is_div_reg   <= bus.op[1];
            neg_main_reg <= a_neg ^ b_neg;
            neg_rem_reg  <= a_neg;
            dbz_pend_reg <= bus.op[1] & (bus.inB == '0);
            addend_reg   <= bus.op[1] ? b_mag : a_mag;
            acc_reg      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          end else begin
            if (bus.hi_we) hi_reg <= bus.wr_data;
            if (bus.lo_we) lo_reg <= bus.wr_data;
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIX: begin
          done_reg <= 1'b1;
          dbz_reg  <= dbz_pend_reg;
          if (is_div_reg) begin
            hi_reg <= hi_fix;
            lo_reg <= lo_fix;
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: expected HI/LO/div_by_zero are queued when an
// operation is launched and compared when done pulses.
module tb_alu_muldiv;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(W)) bus();
  alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results from native 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    case (op)
      MULT:  p = sa * sb;
      MULTU: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) begin
          p = {a, 32'hFFFF_FFFF};
          e.dbz = 1'b1;
        end else if (op == DIV) begin
          p = {32'(sa % sb), 32'(sa / sb)};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  // Drive one start cycle; afterwards operands are scrambled (don't-care).
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input exp_t e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.inA   = a;
    bus.inB   = b;
    if (push) sb_q.push_back(e);
    tick();
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.inA   = $urandom();
    bus.inB   = $urandom();
  endtask

  // Edges until done (-1 on timeout) and how many pre-done samples saw busy.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.done) begin
        edges = i;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== '0) begin
      miscompares++;
      $display("FAIL reset: busy/done/dbz/hi/lo got %b/%b/%b/%h/%h required all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
    end
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_multu_full();
    exp_t e;
    int n, nb;
    bit busy_at_e;
    launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{hi: 32'hFFFF_FFFE, lo: 32'h1, dbz: 1'b0});
    busy_at_e = bus.busy;
    wait_done(n, nb);
    e = sb_q.pop_front();
    vectors++;
    if (n !== 33 || nb !== 32 || busy_at_e !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL multu_timing: done_edge=%0d busy_samples=%0d busy@E=%b busy@done=%b required 33/32/1/0",
               n, nb, busy_at_e, bus.busy);
    end
    vectors++;
    if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      miscompares++;
      $display("FAIL multu_full: hi/lo/dbz got %h/%h/%b required %h/%h/%b",
               bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_signed_ops();
    logic [1:0]   ops [8] = '{MULT, MULT, DIV, DIVU, DIV, DIV, DIVU, DIV};
    logic [W-1:0] as  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFF9, 32'd7,
                              32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
    logic [W-1:0] bs  [8] = '{32'd5, 32'hFFFF_FFFC, 32'd2, 32'd2,
                              32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [W-1:0] his [8] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'd1,
                              32'd1, 32'h0, 32'd5, 32'hFFFF_FFFB};
    logic [W-1:0] los [8] = '{32'hFFFF_FFF1, 32'h10, 32'hFFFF_FFFD, 32'd3,
                              32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bit           zs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t e;
    int n, nb;
    for (int i = 0; i < 8; i++) begin
      launch(ops[i], as[i], bs[i], 1'b1, '{hi: his[i], lo: los[i], dbz: zs[i]});
      wait_done(n, nb);
      e = sb_q.pop_front();
      vectors++;
      if (n !== 33 || {bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
        miscompares++;
        $display("FAIL signed_ops[%0d]: edges/hi/lo/dbz got %0d/%h/%h/%b required 33/%h/%h/%b",
                 i, n, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
      end
    end
    // A clean operation after a divide by zero clears the flag.
    launch(MULTU, 32'd2, 32'd3, 1'b1, '{hi: 32'h0, lo: 32'd6, dbz: 1'b0});
    wait_done(n, nb);
    e = sb_q.pop_front();
    vectors++;
    if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      miscompares++;
      $display("FAIL dbz_clear: hi/lo/dbz got %h/%h/%b required %h/%h/%b",
               bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int n, nb;
    launch(DIVU, 32'd100, 32'd7, 1'b1, '{hi: 32'd2, lo: 32'd14, dbz: 1'b0});
    repeat (4) tick();
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.inA   = 32'd5;
    bus.inB   = 32'd5;
    tick();
    bus.start = 1'b0;
    wait_done(n, nb);
    e = sb_q.pop_front();
    vectors++;
    if (n + 5 !== 33 || {bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      miscompares++;
      $display("FAIL ignore_start: edges/hi/lo/dbz got %0d/%h/%h/%b required 33/%h/%h/%b",
               n + 5, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n, nb;
    launch(MULTU, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, '{hi: 32'h0, lo: 32'h0, dbz: 1'b0});
    repeat (9) tick();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: busy/done/hi/lo got %b/%b/%h/%h required 0/0/0/0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    tick();
    tick();
    reset = 1'b1;
    launch(MULTU, 32'd3, 32'd4, 1'b1, '{hi: 32'h0, lo: 32'd12, dbz: 1'b0});
    wait_done(n, nb);
    e = sb_q.pop_front();
    vectors++;
    if (n !== 33 || {bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      miscompares++;
      $display("FAIL after_reset: edges/hi/lo/dbz got %0d/%h/%h/%b required 33/%h/%h/%b",
               n, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n, nb;
    launch(MULT, 32'd7, 32'hFFFF_FFFA, 1'b1, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFD6, dbz: 1'b0});
    wait_done(n, nb);
    e = sb_q.pop_front();
    vectors++;
    if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      miscompares++;
      $display("FAIL b2b_first: hi/lo/dbz got %h/%h/%b required %h/%h/%b",
               bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
    // Start again in the very cycle done is high.
    launch(MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, '{hi: 32'h1, lo: 32'h0, dbz: 1'b0});
    wait_done(n, nb);
    e = sb_q.pop_front();
    vectors++;
    if (n !== 33 || {bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      miscompares++;
      $display("FAIL b2b_second: edges/hi/lo/dbz got %0d/%h/%h/%b required 33/%h/%h/%b",
               n, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_regwrite();
    exp_t e;
    int n, nb;
    launch(DIVU, 32'd9, 32'd0, 1'b1, '{hi: 32'd9, lo: 32'hFFFF_FFFF, dbz: 1'b1});
    wait_done(n, nb);
    e = sb_q.pop_front();
    vectors++;
    if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      miscompares++;
      $display("FAIL divu_zero: hi/lo/dbz got %h/%h/%b required %h/%h/%b",
               bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
    // Both write enables together; sticky flag untouched.
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h55;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    vectors++;
    if ({bus.hi, bus.lo, bus.div_by_zero} !== {32'h55, 32'h55, 1'b1}) begin
      miscompares++;
      $display("FAIL wr_both: hi/lo/dbz got %h/%h/%b required 00000055/00000055/1",
               bus.hi, bus.lo, bus.div_by_zero);
    end
    bus.hi_we = 1'b1; bus.wr_data = 32'h1234;
    tick();
    bus.hi_we = 1'b0;
    vectors++;
    if ({bus.hi, bus.lo} !== {32'h1234, 32'h55}) begin
      miscompares++;
      $display("FAIL wr_hi: hi/lo got %h/%h required 00001234/00000055", bus.hi, bus.lo);
    end
    // lo_we with start: start wins.
    bus.lo_we = 1'b1; bus.wr_data = 32'hDEAD;
    launch(MULTU, 32'd2, 32'd2, 1'b1, '{hi: 32'h0, lo: 32'd4, dbz: 1'b0});
    bus.lo_we = 1'b0;
    vectors++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b1, 32'h1234, 32'h55}) begin
      miscompares++;
      $display("FAIL wr_vs_start: busy/hi/lo got %b/%h/%h required 1/00001234/00000055",
               bus.busy, bus.hi, bus.lo);
    end
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'hBEEF;
    repeat (3) tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    vectors++;
    if ({bus.hi, bus.lo} !== {32'h1234, 32'h55}) begin
      miscompares++;
      $display("FAIL wr_busy: hi/lo got %h/%h required 00001234/00000055", bus.hi, bus.lo);
    end
    wait_done(n, nb);
    e = sb_q.pop_front();
    vectors++;
    if (n + 3 !== 33 || {bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      miscompares++;
      $display("FAIL wr_then_op: edges/hi/lo/dbz got %0d/%h/%h/%b required 33/%h/%h/%b",
               n + 3, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [1:0] op;
    logic [W-1:0] a, b;
    int n, nb;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = $urandom();
      if (op[1] && $urandom_range(0, 2) == 0) b = $urandom_range(0, 20);
      if (op == DIV && $urandom_range(0, 2) == 0) b = -($urandom_range(1, 20));
      launch(op, a, b, 1'b1, model(op, a, b));
      wait_done(n, nb);
      e = sb_q.pop_front();
      vectors++;
      if (n !== 33 || {bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: edges/hi/lo/dbz got %0d/%h/%h/%b required 33/%h/%h/%b",
                 i, op, a, b, n, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'd0;
    bus.inA     = '0;
    bus.inB     = '0;
    bus.hi_we   = 1'b0;
    bus.lo_we   = 1'b0;
    bus.wr_data = '0;
    test_reset();
    test_multu_full();
    test_signed_ops();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_regwrite();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
